// File: rtl/vsmul_seq_if.sv
//==============================================================================
// Module   : vsmul_seq_if
// Brief    : Operand/result handshake bundle for the sequential FP16
//            vector-by-scalar multiplier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vsmul_seq_if #(
  parameter int LANES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           scalar;
  logic [16*LANES-1:0]   vecin;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*LANES-1:0]   product;
  logic                  ovf;
  logic                  unf;
  logic                  inv;

  modport master (
    output in_valid, scalar, vecin, out_ready,
    input  in_ready, out_valid, product, ovf, unf, inv
  );

  modport slave (
    input  in_valid, scalar, vecin, out_ready,
    output in_ready, out_valid, product, ovf, unf, inv
  );
endinterface

`default_nettype wire

// File: rtl/vsmul_seq.sv
//==============================================================================
// Module   : vsmul_seq
// Brief    : Sequential IEEE binary16 vector-by-scalar multiplier, MULS lanes
//            per cycle, round-to-nearest-even, sticky ovf/unf/inv flags.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vsmul_seq #(
  parameter int LANES = 16,
  parameter int MULS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  vsmul_seq_if.slave  bus
);

  localparam int c_STEPS = LANES / MULS;
  localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns {ovf, unf, inv, result}.
  function automatic logic [18:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              sgn;
    logic [4:0]        ea, eb, xa, xb, lz;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, found, up;
    logic [21:0]       prod, norm;
    logic [11:0]       rsig;
    logic signed [7:0] e;
    logic [18:0]       res;
    sgn    = a[15] ^ b[15];
    ea     = a[14:10];
    eb     = b[14:10];
    a_nan  = (ea == 5'd31) && (a[9:0] != 10'd0);
    b_nan  = (eb == 5'd31) && (b[9:0] != 10'd0);
    a_inf  = (ea == 5'd31) && (a[9:0] == 10'd0);
    b_inf  = (eb == 5'd31) && (b[9:0] == 10'd0);
    a_zero = (ea == 5'd0)  && (a[9:0] == 10'd0);
    b_zero = (eb == 5'd0)  && (b[9:0] == 10'd0);
    xa     = (ea == 5'd0) ? 5'd1 : ea;
    xb     = (eb == 5'd0) ? 5'd1 : eb;
    prod   = {11'd0, (ea != 5'd0), a[9:0]} * {11'd0, (eb != 5'd0), b[9:0]};
    lz     = 5'd0;
    found  = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!found) begin
        if (prod[i]) found = 1'b1;
        else         lz    = lz + 5'd1;
      end
    end
    norm = prod << lz;
    // norm[21] is the hidden bit; value = norm/2^21 * 2^(xa+xb-29-lz)
    e    = $signed({3'b000, xa}) + $signed({3'b000, xb}) - 8'sd14 - $signed({3'b000, lz});
    up   = norm[10] & (norm[11] | norm[9] | (|norm[8:0]));
    rsig = {1'b0, norm[21:11]} + {11'd0, up};
    if (rsig[11]) e = e + 8'sd1;
    if (a_nan || b_nan)
      res = {3'b001, 16'h7E00};
    else if ((a_inf && b_zero) || (b_inf && a_zero))
      res = {3'b001, 16'h7E00};
    else if (a_inf || b_inf)
      res = {3'b000, sgn, 15'h7C00};
    else if (a_zero || b_zero)
      res = {3'b000, sgn, 15'h0000};
    else if (e >= 8'sd31)
      res = {3'b100, sgn, 15'h7C00};
    else if (e <= 8'sd0)
      res = {3'b010, sgn, 15'h0000};
    else
      res = {3'b000, sgn, e[4:0], (rsig[11] ? 10'd0 : rsig[9:0])};
    return res;
  endfunction

  state_t                r_state;
  logic [c_CW-1:0]       r_cnt;
  logic [15:0]           r_scalar;
  logic [16*LANES-1:0]   r_vec;
  logic [16*LANES-1:0]   r_prod;
  logic                  r_ovf, r_unf, r_inv;
  logic                  r_in_ready, r_out_valid;

  logic [16*MULS-1:0]    w_res;
  logic [MULS-1:0]       w_ovf, w_unf, w_inv;
  logic [16*LANES-1:0]   w_prod_nxt, w_vec_nxt;

  // The operand register shifts down MULS lanes per RUN cycle and results
  // enter the product register from the top, landing in lane order at DONE.
  for (genvar j = 0; j < MULS; j++) begin : g_mul
    logic [18:0] w_r;
    assign w_r               = fp16_mul(r_scalar, r_vec[16*j +: 16]);
    assign w_res[16*j +: 16] = w_r[15:0];
    assign w_ovf[j]          = w_r[18];
    assign w_unf[j]          = w_r[17];
    assign w_inv[j]          = w_r[16];
  end

  if (c_STEPS == 1) begin : g_single
    assign w_prod_nxt = w_res;
    assign w_vec_nxt  = r_vec;
  end else begin : g_multi
    assign w_prod_nxt = {w_res, r_prod[16*LANES-1:16*MULS]};
    assign w_vec_nxt  = {{(16*MULS){1'b0}}, r_vec[16*LANES-1:16*MULS]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_scalar    <= '0;
      r_vec       <= '0;
      r_prod      <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inv       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_scalar   <= bus.scalar;
            r_vec      <= bus.vecin;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inv      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_vec  <= w_vec_nxt;
          r_prod <= w_prod_nxt;
          r_ovf  <= r_ovf | (|w_ovf);
          r_unf  <= r_unf | (|w_unf);
          r_inv  <= r_inv | (|w_inv);
          if (r_cnt == c_LAST) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_prod;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;
  assign bus.inv       = r_inv;

endmodule

`default_nettype wire

// File: doc/vsmul_seq.md
Name: vsmul_seq

Overview:
- Sequential, parametrised vector-by-scalar IEEE binary16 multiplier.
- Successor to the combinational 16-lane scalar multiply: time-multiplexes MULS multipliers over LANES lanes.
- Implements correct round-to-nearest-even, NaN/zero/infinity special cases and per-operation exception flags.
- Sits between the vector register file read port and the writeback stage. Uses valid/ready handshakes on input and output.

Parameters:
LANES, 16, number of 16-bit FP16 lanes in vecin/product; must be a multiple of MULS
MULS, 4, FP16 multipliers instantiated; lanes processed per RUN cycle

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  scalar/vecin valid
in_ready  output  1  block can accept an operation
scalar  input  16  FP16 scalar operand
vecin  input  16*LANES  FP16 vector operand, lane i = bits [16i+15:16i]
out_valid  output  1  product and flags valid
out_ready  input  1  consumer accepts result
product  output  16*LANES  FP16 results, lane i matches vecin lane i
ovf  output  1  any lane overflowed to infinity
unf  output  1  any nonzero exact result flushed to zero
inv  output  1  any lane produced NaN

Behaviour:
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture scalar and vecin, clear the lane counter and flags, go to RUN.
  - RUN: in_ready=0. Each cycle, lanes [cnt*MULS .. cnt*MULS+MULS-1] are multiplied and written into the product register, and flags are ORed in. cnt increments by 1. After the cycle with cnt = LANES/MULS-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. Hold product and flags stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Latency: accept at edge 0; out_valid rises after edge LANES/MULS (4 cycles at the defaults).
- Throughput: one operation per LANES/MULS+2 cycles minimum. There is no accept in the same cycle as the DONE handshake.
- Reset (async, any state, including mid-RUN): state=IDLE, cnt=0, product=0, ovf=unf=inv=0, out_valid=0, in_ready=1. A partially computed operation is discarded.
- in_valid while not IDLE is ignored; operands are not sampled. Captured operands are unaffected by input changes during RUN/DONE.
- out_ready outside DONE is ignored.
- Per-lane multiply, with sign = sa XOR sb in all cases:
  - Either operand NaN (exp=31, mant!=0) -> 0x7E00, inv=1.
  - Inf*0 or 0*Inf -> 0x7E00, inv=1.
  - Inf * finite nonzero -> signed infinity, no flag.
  - Either operand zero -> signed zero.
  - Subnormal inputs: implicit bit 0, effective exponent 1.
  - Product: 11x11 = 22-bit significand. Normalise with a leading-zero shift (subnormal inputs) and compute the exponent in signed 8-bit arithmetic with bias 15.
  - Round to nearest-even using guard, round and sticky bits. A rounding carry renormalises and increments the exponent.
  - Biased exponent >= 31 after rounding -> signed infinity (0x7C00|sign), ovf=1.
  - Biased exponent <= 0 -> signed zero, unf=1. No subnormal outputs.
- Flags are sticky across the lanes of one operation and cleared at accept.

Test Plan:
- Reset mid-RUN: assert rst_n=0 at the 2nd RUN cycle -> out_valid=0, in_ready=1, product=0 immediately. A fresh operation afterwards completes normally.
- scalar=0x3C00 (1.0), all lanes 0x4000 -> after 4 cycles out_valid=1, every lane 0x4000, ovf=unf=inv=0. Verify the latency is exactly LANES/MULS.
- scalar=0x4000, lane0=0x7BFF, lane1=0xC000 -> lane0=0x7C00, lane1=0xC400, ovf=1.
- scalar=0x3C01, lane0=0x3C01 -> lane0=0x3C02 (RNE drops 2^-20 term). scalar=0x3800, lane1=0x0400 -> lane1=0x0000, unf=1.
- scalar=0x7C00, lane0=0x0000, lane1=0x8001, lane2=0x7E01 -> lane0=0x7E00, lane1=0xFC00, lane2=0x7E00, inv=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> product stable, in_ready=0. Release -> one handshake, then IDLE. Repeat with MULS=1 and MULS=16 (latency 16 and 1).
